// File: rtl/adder_input_gather_if.sv
// Stream-in / group-out bundle for the adder input gather stage.
// slave: the gather stage itself. master: whatever feeds words and takes groups.
interface adder_input_gather_if #(
    parameter int unsigned BITS = 16,
    parameter int unsigned NUM  = 4
) ();
    localparam int unsigned CntW = $clog2(NUM + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [BITS-1:0]       in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [NUM*BITS-1:0]   out_data;
    logic [CntW-1:0]       out_count;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_count
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_count
    );
endinterface

// File: rtl/adder_input_gather.sv
// Gathers a serial word stream into groups of up to NUM words and presents each
// group as one parallel vector. A fill buffer plus an output register form a
// double buffer, so a full-rate stream with a ready consumer never stalls.
module adder_input_gather #(
    parameter int unsigned BITS = 16,
    parameter int unsigned NUM  = 4
) (
    input logic                  clk,
    input logic                  resetn,
    adder_input_gather_if.slave  bus
);
    localparam int unsigned IdxW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int unsigned CntW = $clog2(NUM + 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM - 1);

    // StPend: fill buffer holds a complete group waiting for the output register.
    typedef enum logic {StFill, StPend} state_e;

    state_e                state_q;
    logic                  in_ready_q;
    logic [IdxW-1:0]       idx_q;
    logic [NUM*BITS-1:0]   fill_q;
    logic [CntW-1:0]       pend_cnt_q;
    logic [NUM*BITS-1:0]   out_data_q;
    logic [CntW-1:0]       out_count_q;
    logic                  out_valid_q;

    logic                  beat;
    logic                  grp_end;
    logic                  out_free;
    logic [CntW-1:0]       grp_cnt;
    logic [NUM*BITS-1:0]   grp_data;

    // Current beat merged into the fill buffer, so a closing word lands in the
    // output register on the same edge it is accepted.
    always_comb begin
        beat     = bus.in_valid & in_ready_q;
        grp_end  = beat & ((idx_q == IdxLast) | bus.in_last);
        out_free = ~out_valid_q | bus.out_ready;
        grp_cnt  = CntW'(idx_q) + CntW'(1);
        grp_data = fill_q;
        grp_data[int'(idx_q) * BITS +: BITS] = bus.in_data;
    end

    // Gather FSM with registered in_ready; out_ready only affects the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StFill;
            in_ready_q  <= 1'b1;
            idx_q       <= '0;
            fill_q      <= '0;
            pend_cnt_q  <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StFill: begin
                    if (grp_end) begin
                        if (out_free) begin
                            out_data_q  <= grp_data;
                            out_count_q <= grp_cnt;
                            out_valid_q <= 1'b1;
                            idx_q       <= '0;
                            fill_q      <= '0;
                        end else begin
                            // Output still held downstream: park the group.
                            fill_q      <= grp_data;
                            pend_cnt_q  <= grp_cnt;
                            state_q     <= StPend;
                            in_ready_q  <= 1'b0;
                        end
                    end else begin
                        if (beat) begin
                            fill_q <= grp_data;
                            idx_q  <= idx_q + IdxW'(1);
                        end
                        if (out_valid_q && bus.out_ready) begin
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                StPend: begin
                    // out_valid is always set here; a transfer swaps in the parked group.
                    if (bus.out_ready) begin
                        out_data_q  <= fill_q;
                        out_count_q <= pend_cnt_q;
                        idx_q       <= '0;
                        fill_q      <= '0;
                        state_q     <= StFill;
                        in_ready_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.in_ready  = in_ready_q;
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
        bus.out_count = out_count_q;
    end
endmodule

// File: tb/tb_adder_input_gather.sv
// Bench for adder_input_gather: directed cases with literal expectations plus a
// randomized phase, all checked against a queue-based group model.
module tb_adder_input_gather;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    adder_input_gather_if #(.BITS(16), .NUM(4)) b4 ();
    adder_input_gather_if #(.BITS(16), .NUM(1)) b1 ();

    adder_input_gather #(.BITS(16), .NUM(4)) u4 (.clk(clk), .resetn(resetn), .bus(b4));
    adder_input_gather #(.BITS(16), .NUM(1)) u1 (.clk(clk), .resetn(resetn), .bus(b1));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words accumulate until NUM or in_last, then become a group.
    typedef struct packed {
        logic [63:0] d;
        logic [2:0]  c;
    } grp_t;

    logic [15:0] part4[$];
    grp_t        exp4[$];
    logic [15:0] exp1[$];
    logic        hold4 = 1'b0;
    logic [63:0] hold_d;
    logic [2:0]  hold_c;
    logic        rdy_always = 1'b0;

    // Compare process: at each negedge, look at what the coming posedge will do.
    always @(negedge clk) begin
        if (!resetn) begin
            part4.delete();
            exp4.delete();
            exp1.delete();
            hold4 = 1'b0;
        end else begin
            if (hold4) begin
                chk("stable_valid", b4.out_valid, 1'b1);
                chk("stable_data", b4.out_data, hold_d);
                chk("stable_count", b4.out_count, hold_c);
            end
            if (b4.out_valid && b4.out_ready) begin
                chk("group_expected", exp4.size() != 0, 1'b1);
                if (exp4.size() != 0) begin
                    grp_t g;
                    g = exp4.pop_front();
                    chk("group_data", b4.out_data, g.d);
                    chk("group_count", b4.out_count, g.c);
                end
            end
            hold4  = b4.out_valid && !b4.out_ready;
            hold_d = b4.out_data;
            hold_c = b4.out_count;
            if (rdy_always) chk("sustained_in_ready", b4.in_ready, 1'b1);
            if (b4.in_valid && b4.in_ready) begin
                part4.push_back(b4.in_data);
                if (part4.size() == 4 || b4.in_last) begin
                    grp_t g;
                    g.d = '0;
                    foreach (part4[k]) g.d[k*16 +: 16] = part4[k];
                    g.c = 3'(part4.size());
                    exp4.push_back(g);
                    part4.delete();
                end
            end
            if (b1.out_valid && b1.out_ready) begin
                chk("n1_expected", exp1.size() != 0, 1'b1);
                if (exp1.size() != 0) begin
                    logic [15:0] w;
                    w = exp1.pop_front();
                    chk("n1_data", b1.out_data, w);
                    chk("n1_count", b1.out_count, 1);
                end
            end
            if (b1.in_valid && b1.in_ready) exp1.push_back(b1.in_data);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word was accepted.
    task automatic send4(input logic [15:0] w, input logic l);
        b4.in_valid = 1'b1;
        b4.in_data  = w;
        b4.in_last  = l;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b4.in_ready) break;
        end
        if (!b4.in_ready) chk("in_ready_wait", b4.in_ready, 1'b1);
        @(posedge clk);
        #1;
        b4.in_valid = 1'b0;
        b4.in_last  = 1'b0;
    endtask

    task automatic send1(input logic [15:0] w);
        b1.in_valid = 1'b1;
        b1.in_data  = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b1.in_ready) break;
        end
        if (!b1.in_ready) chk("n1_in_ready_wait", b1.in_ready, 1'b1);
        @(posedge clk);
        #1;
        b1.in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, b4.in_ready, 1'b1);
        chk({tag, "_out_valid"}, b4.out_valid, 1'b0);
        chk({tag, "_out_data"}, b4.out_data, 64'h0);
        chk({tag, "_out_count"}, b4.out_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b4.in_valid = 1'b0; b4.in_data = '0; b4.in_last = 1'b0; b4.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.in_last = 1'b0; b1.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        chk("n1_reset_valid", b1.out_valid, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // 1. Full group
        b4.out_ready = 1'b1;
        send4(16'h3988, 1'b0);
        send4(16'h3f6a, 1'b0);
        send4(16'h0f17, 1'b0);
        chk("t1_not_yet", b4.out_valid, 1'b0);
        send4(16'h20a6, 1'b0);
        chk("t1_valid", b4.out_valid, 1'b1);
        chk("t1_data", b4.out_data, 64'h20a6_0f17_3f6a_3988);
        chk("t1_count", b4.out_count, 4);
        step();
        chk("t1_valid_drop", b4.out_valid, 1'b0);
        chk("t1_data_kept", b4.out_data, 64'h20a6_0f17_3f6a_3988);

        // 2. Early close
        send4(16'h0c03, 1'b0);
        send4(16'h1adf, 1'b1);
        chk("t2_valid", b4.out_valid, 1'b1);
        chk("t2_data", b4.out_data, 64'h0000_0000_1adf_0c03);
        chk("t2_count", b4.out_count, 2);
        step();

        // 3. Backpressure
        b4.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send4(16'h1000 + 16'(i), 1'b0);
        chk("t3_in_ready_low", b4.in_ready, 1'b0);
        chk("t3_g1_data", b4.out_data, 64'h1003_1002_1001_1000);
        repeat (2) step();
        chk("t3_g1_held", b4.out_data, 64'h1003_1002_1001_1000);
        chk("t3_still_pend", b4.in_ready, 1'b0);
        b4.out_ready = 1'b1;
        step();
        chk("t3_g2_valid", b4.out_valid, 1'b1);
        chk("t3_g2_data", b4.out_data, 64'h1007_1006_1005_1004);
        chk("t3_g2_count", b4.out_count, 4);
        chk("t3_in_ready_back", b4.in_ready, 1'b1);
        step();
        chk("t3_drained", b4.out_valid, 1'b0);

        // 4. Throughput
        rdy_always = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            send4(16'($urandom), 1'b0);
            chk("t4_valid_pulse", b4.out_valid, (i % 4) == 0);
        end
        step();
        rdy_always = 1'b0;

        // 5. Reset mid-group
        send4(16'haaaa, 1'b0);
        send4(16'hbbbb, 1'b0);
        #2 resetn = 1'b0;
        #1;
        check_reset_vals("t5_reset");
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        step();
        chk("t5_no_output", b4.out_valid, 1'b0);
        send4(16'h0001, 1'b0);
        send4(16'h0002, 1'b0);
        send4(16'h0003, 1'b0);
        send4(16'h0004, 1'b0);
        chk("t5_valid", b4.out_valid, 1'b1);
        chk("t5_data", b4.out_data, 64'h0004_0003_0002_0001);
        step();

        // 6. NUM=1
        b1.out_ready = 1'b1;
        send1(16'h0045);
        chk("t6_valid_a", b1.out_valid, 1'b1);
        chk("t6_data_a", b1.out_data, 16'h0045);
        chk("t6_count_a", b1.out_count, 1);
        send1(16'h3902);
        chk("t6_valid_b", b1.out_valid, 1'b1);
        chk("t6_data_b", b1.out_data, 16'h3902);
        step();
        chk("t6_done", b1.out_valid, 1'b0);

        // Randomized phase on both instances
        for (int i = 0; i < 500; i++) begin
            b4.out_ready = ($urandom_range(0, 99) < 60);
            b4.in_valid  = ($urandom_range(0, 99) < 70);
            b4.in_last   = ($urandom_range(0, 99) < 15);
            b4.in_data   = 16'($urandom);
            b1.out_ready = ($urandom_range(0, 99) < 50);
            b1.in_valid  = ($urandom_range(0, 99) < 70);
            b1.in_data   = 16'($urandom);
            step();
        end
        b4.in_valid = 1'b0;
        b4.in_last  = 1'b0;
        b1.in_valid = 1'b0;
        b4.out_ready = 1'b1;
        b1.out_ready = 1'b1;
        send4(16'($urandom), 1'b1);
        repeat (6) step();
        chk("drain_exp4_empty", exp4.size(), 0);
        chk("drain_exp1_empty", exp1.size(), 0);
        chk("drain_valid4", b4.out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
